// File: rtl/reg_lock_arbiter_if.sv
// Request/response bundle for the lockable protected register.
// The master side drives requests; the slave side is the arbiter.
interface reg_lock_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       req;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             lock_req;
  logic             lock_override;
  logic [1:0]       gnt;
  logic [1:0]       err;
  logic [WIDTH-1:0] data_out;
  logic             locked;
  logic [7:0]       rej_cnt;

  modport master (
    output req, wdata0, wdata1, lock_req, lock_override,
    input  gnt, err, data_out, locked, rej_cnt
  );

  modport slave (
    input  req, wdata0, wdata1, lock_req, lock_override,
    output gnt, err, data_out, locked, rej_cnt
  );
endinterface

// File: rtl/reg_lock_arbiter.sv
// Two-requester round-robin writer for a single protected register.
// Writes are rejected once the sticky lock is set, unless the debug override is applied.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures winner data
// WRITE | applies lock check, commits or rejects the captured write
// DONE  | gnt/err and new data_out visible for this single cycle
module reg_lock_arbiter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  reg_lock_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic             win_q, win_nxt;
  logic             rr_q, rr_nxt;
  logic [WIDTH-1:0] cap_q, cap_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             locked_q, locked_nxt;
  logic [1:0]       gnt_q, gnt_nxt;
  logic [1:0]       err_q, err_nxt;
  logic [7:0]       rej_q, rej_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      rr_q     <= 1'b0;
      cap_q    <= RESET_VAL;
      data_q   <= RESET_VAL;
      locked_q <= 1'b0;
      gnt_q    <= 2'b00;
      err_q    <= 2'b00;
      rej_q    <= 8'h00;
    end else begin
      state_q  <= state_nxt;
      win_q    <= win_nxt;
      rr_q     <= rr_nxt;
      cap_q    <= cap_nxt;
      data_q   <= data_nxt;
      locked_q <= locked_nxt;
      gnt_q    <= gnt_nxt;
      err_q    <= err_nxt;
      rej_q    <= rej_nxt;
    end
  end

  // rr_q is the index that wins a tie; it always moves to the loser of the last outcome.
  always_comb begin
    state_nxt  = state_q;
    win_nxt    = win_q;
    rr_nxt     = rr_q;
    cap_nxt    = cap_q;
    data_nxt   = data_q;
    gnt_nxt    = 2'b00;
    err_nxt    = 2'b00;
    rej_nxt    = rej_q;
    locked_nxt = locked_q | bus.lock_req;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          if (bus.req == 2'b11) win_nxt = rr_q;
          else                  win_nxt = bus.req[1];
          cap_nxt   = win_nxt ? bus.wdata1 : bus.wdata0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        rr_nxt = ~win_q;
        // locked_q is the pre-edge value, so a lock_req arriving now only affects later writes
        if (!locked_q || bus.lock_override) begin
          data_nxt = cap_q;
          gnt_nxt  = win_q ? 2'b10 : 2'b01;
        end else begin
          err_nxt = win_q ? 2'b10 : 2'b01;
          if (rej_q != 8'hFF) rej_nxt = rej_q + 8'd1;
        end
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_q;
  assign bus.locked   = locked_q;
  assign bus.rej_cnt  = rej_q;

endmodule

// File: tb/tb_reg_lock_arbiter.sv
// Scoreboard bench for reg_lock_arbiter: drivers queue expected responses,
// a monitor pops and compares whenever gnt or err fires.
module tb_reg_lock_arbiter;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  err;
    logic [15:0] data;
    logic        locked;
    logic [7:0]  rej;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_lock_arbiter_if #(.WIDTH(16)) bus();

  reg_lock_arbiter #(
    .WIDTH(16),
    .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.gnt | bus.err) != 2'b00) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got gnt=%b err=%b data=%h at cyc %0d, want no response",
                   bus.gnt, bus.err, bus.data_out, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.gnt !== e.gnt || bus.err !== e.err || bus.data_out !== e.data ||
              bus.locked !== e.locked || bus.rej_cnt !== e.rej || cyc != e.cyc) begin
            fails++;
            $display("FAIL resp: got gnt=%b err=%b data=%h locked=%b rej=%0d cyc=%0d, want gnt=%b err=%b data=%h locked=%b rej=%0d cyc=%0d",
                     bus.gnt, bus.err, bus.data_out, bus.locked, bus.rej_cnt, cyc,
                     e.gnt, e.err, e.data, e.locked, e.rej, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic do_write(input logic [1:0] r, input logic [15:0] w0, input logic [15:0] w1,
                          input logic lk, input logic ov,
                          input logic [1:0] eg, input logic [1:0] ee, input logic [15:0] ed,
                          input logic el, input logic [7:0] er);
    int n;
    bus.req    = r;
    bus.wdata0 = w0;
    bus.wdata1 = w1;
    sb.push_back('{eg, ee, ed, el, er, cyc + 2});
    @(negedge clk);
    bus.lock_req      = lk;
    bus.lock_override = ov;
    bus.wdata0        = ~w0;
    bus.wdata1        = ~w1;
    @(negedge clk);
    bus.lock_req      = 1'b0;
    bus.lock_override = 1'b0;
    n = 0;
    while ((bus.gnt | bus.err) == 2'b00 && n < 6) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ((bus.gnt | bus.err) == 2'b00) begin
      fails++;
      $display("FAIL write_timeout: got no gnt/err after %0d cycles, want response", n + 2);
    end
    bus.req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;
    reset             = 1'b1;
    bus.req           = 2'b00;
    bus.wdata0        = 16'h0000;
    bus.wdata1        = 16'h0000;
    bus.lock_req      = 1'b0;
    bus.lock_override = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(bus.data_out), 32'h0000);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rej", 32'(bus.rej_cnt), 32'h0);

    // tie fairness with req held: 01, 10, 01 three cycles apart
    bus.req    = 2'b11;
    bus.wdata0 = 16'h1111;
    bus.wdata1 = 16'h2222;
    sb.push_back('{2'b01, 2'b00, 16'h1111, 1'b0, 8'd0, cyc + 2});
    sb.push_back('{2'b10, 2'b00, 16'h2222, 1'b0, 8'd0, cyc + 5});
    sb.push_back('{2'b01, 2'b00, 16'h1111, 1'b0, 8'd0, cyc + 8});
    seen = 0;
    n = 0;
    while (seen < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if ((bus.gnt | bus.err) != 2'b00) seen++;
    end
    tests++;
    if (seen < 3) begin
      fails++;
      $display("FAIL tie_timeout: got %0d responses, want 3", seen);
    end
    bus.req = 2'b00;
    @(negedge clk);

    do_write(2'b01, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 16'hA5A5, 1'b0, 8'd0);
    do_write(2'b10, 16'h0000, 16'h3C3C, 1'b0, 1'b0, 2'b10, 2'b00, 16'h3C3C, 1'b0, 8'd0);
    // lock_req in WRITE: this write lands, the next is rejected
    do_write(2'b01, 16'h5555, 16'h0000, 1'b1, 1'b0, 2'b01, 2'b00, 16'h5555, 1'b1, 8'd0);
    do_write(2'b10, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2'b00, 2'b10, 16'h5555, 1'b1, 8'd1);
    do_write(2'b01, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 2'b01, 2'b00, 16'h0F0F, 1'b1, 8'd1);
    chk("ovr_locked_stays", 32'(bus.locked), 32'h1);

    // reset during WRITE aborts the transaction
    bus.req    = 2'b01;
    bus.wdata0 = 16'h1234;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.req = 2'b00;
    reset   = 1'b0;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    chk("mid_rst_data", 32'(bus.data_out), 32'h0000);
    chk("mid_rst_locked", 32'(bus.locked), 32'h0);
    chk("mid_rst_rej", 32'(bus.rej_cnt), 32'h0);
    repeat (3) @(negedge clk);

    bus.lock_req = 1'b1;
    @(negedge clk);
    bus.lock_req = 1'b0;
    @(negedge clk);
    chk("lock_set", 32'(bus.locked), 32'h1);
    for (int i = 0; i < 300; i++) begin
      logic [1:0] r;
      logic [7:0] er;
      r  = i[0] ? 2'b10 : 2'b01;
      er = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      do_write(r, 16'(i), 16'(~i), 1'b0, 1'b0, 2'b00, r, 16'h0000, 1'b1, er);
    end
    chk("sat_rej", 32'(bus.rej_cnt), 32'hFF);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_lock_arbiter.md
REG_LOCK_ARBITER -- requirements
Module: reg_lock_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: protected register width.
REQ-002 The block SHALL have parameter RESET_VAL, default 16'h0000: data_out value after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 2 bits: per-requester write request, level, held until gnt or err.
REQ-006 The block SHALL have port wdata0, input, WIDTH bits: requester 0 write data.
REQ-007 The block SHALL have port wdata1, input, WIDTH bits: requester 1 write data.
REQ-008 The block SHALL have port lock_req, input, 1 bit: sets the sticky lock.
REQ-009 The block SHALL have port lock_override, input, 1 bit: debug override permitting writes while locked.
REQ-010 The block SHALL have port gnt, output, 2 bits: one-hot, one-cycle write-accepted pulse.
REQ-011 The block SHALL have port err, output, 2 bits: one-hot, one-cycle write-rejected pulse.
REQ-012 The block SHALL have port data_out, output, WIDTH bits: protected register contents.
REQ-013 The block SHALL have port locked, output, 1 bit: current lock state.
REQ-014 The block SHALL have port rej_cnt, output, 8 bits: count of rejected writes, saturating.

Function
REQ-015 The block SHALL implement the FSM states IDLE, WRITE and DONE; all outputs are registered.
REQ-016 In IDLE with req==0, the block SHALL remain in IDLE.
REQ-017 In IDLE with any req bit set, the block SHALL select a winner, capture the winner index and its wdata, and go to WRITE.
REQ-018 Winner selection SHALL use 2-way round-robin: a single requester wins; on tie the requester not granted last wins; the pointer after reset favours requester 0.
REQ-019 The round-robin pointer SHALL update on both accept and reject outcomes.
REQ-020 In WRITE, if locked==0 or lock_override==1, the block SHALL load data_out with the captured data and set gnt[winner]; otherwise data_out SHALL hold and err[winner] is set.
REQ-021 In WRITE, the block SHALL go to DONE.
REQ-022 In DONE, gnt/err SHALL be visible for exactly this one cycle, together with the new data_out, and the block SHALL return to IDLE.
REQ-023 Latency: req sampled in cycle N (IDLE) SHALL give gnt/err and updated data_out in cycle N+2; the next arbitration SHALL be no earlier than N+3.
REQ-024 A requester SHALL drop req in the cycle after its gnt/err; the block samples req only in IDLE.
REQ-025 Captured data SHALL be used in WRITE; wdata changes after capture SHALL be ignored.
REQ-026 locked SHALL be set to 1 on any cycle with lock_req==1 and SHALL be cleared only by reset.
REQ-027 The WRITE-cycle check SHALL use locked as registered before the edge, so lock_req asserted during WRITE does not block that write.
REQ-028 lock_override SHALL be sampled only in the WRITE cycle and SHALL NOT clear locked.
REQ-029 rej_cnt SHALL increment by 1 on each reject and saturate at 8'hFF, with no wrap.
REQ-030 gnt and err SHALL never be asserted together, and at most one bit of either SHALL be set.

Reset
REQ-031 On reset, the block SHALL set state=IDLE, data_out=RESET_VAL, locked=0, gnt=0, err=0, rej_cnt=0, and the round-robin pointer to favour requester 0.
REQ-032 Reset in WRITE or DONE SHALL abort the transaction: no gnt/err is issued and data_out=RESET_VAL.
REQ-033 Reset SHALL have priority over all other inputs.

Verification
REQ-034 Unlocked single write: req=2'b01, wdata0=16'hA5A5 at N -> gnt=2'b01 and data_out=16'hA5A5 at N+2, err=0.
REQ-035 Tie fairness: req=2'b11 held continuously, wdata0=16'h1111, wdata1=16'h2222 -> gnt order 01, 10, 01, each 3 cycles apart, data_out alternating accordingly.
REQ-036 Locked reject: lock_req pulse, then req=2'b10, wdata1=16'hBEEF -> err=2'b10 at N+2, data_out unchanged, rej_cnt=1, locked=1.
REQ-037 Override: locked=1, lock_override=1 during WRITE, req=2'b01, wdata0=16'h0F0F -> gnt=2'b01, data_out=16'h0F0F, locked stays 1.
REQ-038 Lock race and saturation: lock_req asserted in the WRITE cycle -> that write is granted, the next is rejected; 300 rejects -> rej_cnt=8'hFF.
REQ-039 Reset mid-operation: reset asserted in the WRITE cycle -> no gnt/err, data_out=16'h0000, locked=0, rej_cnt=0 next cycle.
